// File: rtl/wb_burst_sink.sv
// Wishbone B4 write-only sink: classic/incrementing-burst writes land in a FWFT FIFO drained as a valid/ready stream.
// Define WB_BURST_SINK_ADDR_CHECK_EN to error burst beats whose address breaks the +4 sequence.
module wb_burst_sink #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WINDOW_LOG2 = 12,
  parameter int          DEPTH_LOG2  = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [2:0]            wbs_cti_i,
  input  logic [1:0]            wbs_bte_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [31:0]           dat_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  flush_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [15:0]           beat_count_o,
  output logic                  burst_done_o,
  output logic                  seq_err_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
`ifdef WB_BURST_SINK_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ACK, ERR, RTY, GAP} state_t;

  state_t                state;
  logic [31:0]           exp_adr;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   occ_next;
  logic                  req, in_win, cti_ok, malformed, bad, push, pop;

  assign req    = wbs_cyc_i & wbs_stb_i;
  assign in_win = wbs_adr_i[31:WINDOW_LOG2] == BASE_ADDR[31:WINDOW_LOG2];
  assign cti_ok = (wbs_cti_i == CTI_CLASSIC) || (wbs_cti_i == CTI_INCR) || (wbs_cti_i == CTI_END);
  assign malformed = !wbs_we_i || (wbs_sel_i != 4'hF) || !in_win || !cti_ok ||
                     ((wbs_cti_i == CTI_INCR) && (wbs_bte_i != 2'b00));
  assign bad    = !in_win || (ADDR_CHECK && (wbs_adr_i != exp_adr));

  // Only the in-burst ack/err depend on the live bus; everything else decodes the state register.
  assign wbs_ack_o = (state == ACK) && req && !bad;
  assign wbs_err_o = (state == ERR) || ((state == ACK) && req && bad);
  assign wbs_rty_o = (state == RTY);
  assign wbs_dat_o = '0;

  assign push     = wbs_ack_o && !flush_i;
  assign valid_o  = level_o != '0;
  assign pop      = valid_o && ready_i;
  assign occ_next = level_o + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
  assign dat_o    = valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wbs_dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      level_o <= occ_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      exp_adr      <= '0;
      beat_count_o <= '0;
      burst_done_o <= 1'b0;
      seq_err_o    <= 1'b0;
    end else begin
      burst_done_o <= push && (wbs_cti_i == CTI_END);
      if (wbs_ack_o) beat_count_o <= beat_count_o + 16'd1;
      if (flush_i) begin
        state     <= IDLE;
        seq_err_o <= 1'b0;
      end else begin
        if (wbs_err_o) seq_err_o <= 1'b1;
        case (state)
          IDLE, GAP: begin
            if (!req)                  state <= IDLE;
            else if (malformed)        state <= ERR;
            else if (occ_next == FULL) state <= RTY;
            else begin
              state   <= ACK;
              exp_adr <= wbs_adr_i;
            end
          end
          ACK: begin
            if (wbs_ack_o) exp_adr <= exp_adr + 32'd4;
            // Stay only while the burst continues and the next beat still fits.
            if (bad || !req)                                        state <= GAP;
            else if ((wbs_cti_i == CTI_INCR) && (occ_next < FULL))  state <= ACK;
            else                                                    state <= GAP;
          end
          ERR, RTY: state <= GAP;
          default:  state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wb_burst_sink.sv
// Scoreboard bench for wb_burst_sink: stimulus queues expected terminations/stream words, a monitor checks them.
module tb_wb_burst_sink;
  localparam logic [31:0] BASE = 32'h0004_0000;
  localparam int WL = 12;
  localparam int DL = 3;
  localparam int T_NONE = 0, T_ACK = 1, T_ERR = 2, T_RTY = 3;
`ifdef WB_BURST_SINK_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] rdat, sdat;
  logic        ack, err, rty, svalid, bdone, serr;
  logic        ready = 1'b0, flush = 1'b0;
  logic [DL:0] level;
  logic [15:0] beats;

  int          vectors = 0, miscompares = 0, done_cnt = 0;
  int          exp_term[$];
  logic [31:0] exp_dat[$];

  always #5 clk = ~clk;

  wb_burst_sink #(.BASE_ADDR(BASE), .WINDOW_LOG2(WL), .DEPTH_LOG2(DL)) dut (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_dat_o(rdat), .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty),
    .dat_o(sdat), .valid_o(svalid), .ready_i(ready), .flush_i(flush), .level_o(level),
    .beat_count_o(beats), .burst_done_o(bdone), .seq_err_o(serr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every termination and every stream pop is matched against the queued expectation.
  always @(negedge clk) begin
    int code;
    if (!rst) begin
      if (ack || err || rty) begin
        code = ack ? T_ACK : (err ? T_ERR : T_RTY);
        check("term_onehot", $countones({ack, err, rty}), 1);
        check("wbs_dat_o", rdat, 32'h0);
        if (exp_term.size() == 0) check("term_unexpected", code, T_NONE);
        else                      check("term", code, exp_term.pop_front());
      end
      if (svalid && ready) begin
        if (exp_dat.size() == 0) check("stream_unexpected", sdat, 32'hxxxx_xxxx);
        else                     check("stream_dat", sdat, exp_dat.pop_front());
      end
      if (bdone) done_cnt++;
    end
  end

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c, input logic w,
                      input logic [3:0] s, input int expc, output int got, output int wt);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; cti = c; sel = s;
    exp_term.push_back(expc);
    if (expc == T_ACK) exp_dat.push_back(d);
    got = T_NONE;
    wt  = 0;
    while (got == T_NONE && wt < 20) begin
      @(negedge clk);
      wt++;
      if (ack)      got = T_ACK;
      else if (err) got = T_ERR;
      else if (rty) got = T_RTY;
      @(posedge clk); #1;
    end
    if (got == T_NONE) begin
      check("beat_timeout", got, expc);
      void'(exp_term.pop_back());
      if (expc == T_ACK) void'(exp_dat.pop_back());
    end
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; sel = 4'h0;
  endtask

  task automatic pop_n(input int n);
    ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_dat.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int got, wt, total, d0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_rty", rty, 0);
    check("rst_valid", svalid, 0);
    check("rst_dat", sdat, 0);
    check("rst_level", level, 0);
    check("rst_beats", beats, 0);
    check("rst_done", bdone, 0);
    check("rst_seqerr", serr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // classic write: ack next cycle, FWFT word visible right after the push edge
    beat(BASE, 32'hDEADBEEF, 3'b000, 1'b1, 4'hF, T_ACK, got, wt);
    check("classic_latency", wt, 2);
    check("classic_valid", svalid, 1);
    check("classic_dat", sdat, 32'hDEADBEEF);
    check("classic_beats", beats, 1);
    idle();
    pop_n(1);
    check("classic_level_after_pop", level, 0);

    // 8-beat burst, stream stalled
    d0 = done_cnt; total = 0;
    for (int i = 0; i < 8; i++) begin
      beat(BASE + 32'h100 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), (i == 7) ? 3'b111 : 3'b010, 1'b1, 4'hF,
           T_ACK, got, wt);
      total += wt;
      if (got != T_ACK) break;
    end
    idle();
    check("burst8_cycles", total, 9);
    check("burst8_level", level, 8);
    @(posedge clk); #1;
    check("burst8_done_pulses", done_cnt - d0, 1);
    check("burst8_beats", beats, 9);

    // full FIFO: new write is retried, not errored
    beat(BASE + 32'h40, 32'h1111_1111, 3'b000, 1'b1, 4'hF, T_RTY, got, wt);
    idle();
    check("full_level", level, 8);
    check("full_seqerr", serr, 0);
    pop_n(8);
    check("drain_level", level, 0);
    check("drain_valid", svalid, 0);

    // 10-beat burst into 8-deep FIFO: 8 acks, then retry; pop one and the retry lands
    for (int i = 0; i < 10; i++) begin
      beat(BASE + 32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 3'b010, 1'b1, 4'hF,
           (i < 8) ? T_ACK : T_RTY, got, wt);
      if (got != T_ACK) break;
    end
    idle();
    check("ovf_level", level, 8);
    pop_n(1);
    check("ovf_level_pop", level, 7);
    d0 = done_cnt;
    beat(BASE + 32'h220, 32'hC0DE_0008, 3'b111, 1'b1, 4'hF, T_ACK, got, wt);
    idle();
    check("retry_level", level, 8);
    check("retry_beats", beats, 18);
    @(posedge clk); #1;
    check("retry_done", done_cnt - d0, 1);

    // malformed / out-of-window accesses err even with the FIFO full
    beat(BASE + 32'h1000, 32'h0BAD_0001, 3'b000, 1'b1, 4'hF, T_ERR, got, wt);
    idle();
    check("oow_level", level, 8);
    check("oow_seqerr", serr, 1);
    beat(BASE - 32'h4, 32'h0BAD_0002, 3'b000, 1'b1, 4'hF, T_ERR, got, wt);
    beat(BASE + 32'h4, 32'h0BAD_0003, 3'b000, 1'b0, 4'hF, T_ERR, got, wt);
    beat(BASE + 32'h8, 32'h0BAD_0004, 3'b000, 1'b1, 4'h3, T_ERR, got, wt);
    beat(BASE + 32'h8, 32'h0BAD_0005, 3'b001, 1'b1, 4'hF, T_ERR, got, wt);
    bte = 2'b01;
    beat(BASE + 32'h8, 32'h0BAD_0006, 3'b010, 1'b1, 4'hF, T_ERR, got, wt);
    bte = 2'b00;
    idle();
    check("err_beats", beats, 18);
    check("err_level", level, 8);
    do_flush();
    check("flush_level", level, 0);
    check("flush_valid", svalid, 0);
    check("flush_seqerr", serr, 0);
    check("flush_beats", beats, 18);

    // burst running off the window end errors at the first outside beat
    for (int i = 0; i < 3; i++) begin
      beat(BASE + 32'hFF8 + 32'(4 * i), 32'hE000_0000 + 32'(i), 3'b010, 1'b1, 4'hF,
           (i < 2) ? T_ACK : T_ERR, got, wt);
      if (got != T_ACK) break;
    end
    idle();
    check("cross_level", level, 2);
    check("cross_seqerr", serr, 1);
    do_flush();

    // address-sequence break on the third beat
    d0 = done_cnt;
    beat(BASE + 32'h300, 32'hF000_0000, 3'b010, 1'b1, 4'hF, T_ACK, got, wt);
    beat(BASE + 32'h304, 32'hF000_0001, 3'b010, 1'b1, 4'hF, T_ACK, got, wt);
    beat(BASE + 32'h310, 32'hF000_0002, 3'b111, 1'b1, 4'hF, CHK ? T_ERR : T_ACK, got, wt);
    idle();
    check("seq_level", level, CHK ? 2 : 3);
    @(posedge clk); #1;
    check("seq_done", done_cnt - d0, CHK ? 0 : 1);
    do_flush();

    // reset in the middle of a burst
    for (int i = 0; i < 5; i++) begin
      beat(BASE + 32'h400 + 32'(4 * i), 32'h5000_0000 + 32'(i), 3'b010, 1'b1, 4'hF, T_ACK, got, wt);
      if (got != T_ACK) break;
    end
    check("mid_level", level, 5);
    adr = BASE + 32'h414; wdat = 32'h5000_0005;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_rty", rty, 0);
    check("mid_rst_valid", svalid, 0);
    check("mid_rst_dat", sdat, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_beats", beats, 0);
    check("mid_rst_seqerr", serr, 0);
    exp_dat.delete();
    idle();
    @(posedge clk); #1;
    rst = 1'b0;

    // fresh classic writes after reset, back to back: two cycles per word
    beat(BASE + 32'h8, 32'h600D_F00D, 3'b000, 1'b1, 4'hF, T_ACK, got, wt);
    check("post_rst_beats", beats, 1);
    beat(BASE + 32'hC, 32'h600D_F00E, 3'b000, 1'b1, 4'hF, T_ACK, got, wt);
    check("classic_b2b_cycles", wt, 2);
    idle();
    check("post_rst_level", level, 2);
    pop_n(2);
    check("post_rst_drain", level, 0);

    repeat (2) @(posedge clk); #1;
    check("exp_term_left", exp_term.size(), 0);
    check("exp_dat_left", exp_dat.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_burst_sink.md
# wb_burst_sink

Wishbone B4 slave that accepts write-only traffic, classic single writes and incrementing bursts (CTI 010/111), from the DMA engine's write master, and pushes each accepted 32-bit word into an internal first-word-fall-through FIFO. The FIFO drains onto a valid/ready stream toward downstream consumers. It is the responder for the DMA write path, with retry on back-pressure and error on malformed or out-of-window accesses.

## Interface
- BASE_ADDR, 32'h0000_0000, byte base address of the accepted window
- WINDOW_LOG2, 12, window size = 2^WINDOW_LOG2 bytes
- DEPTH_LOG2, 9, FIFO depth = 2^DEPTH_LOG2 words (DEPTH)
- clk_i  in  1  sole clock
- rst_i  in  1  reset, asynchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone cycle/strobe/write
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_sel_i  in  4  byte selects
- wbs_cti_i  in  3  cycle type
- wbs_bte_i  in  2  burst type
- wbs_dat_o  out  32  read data, tied 0
- wbs_ack_o, wbs_err_o, wbs_rty_o  out  1  termination
- dat_o  out  32  stream data, FWFT
- valid_o  out  1  FIFO not empty
- ready_i  in  1  pop when valid_o && ready_i
- flush_i  in  1  synchronous FIFO/FSM clear
- level_o  out  DEPTH_LOG2+1  FIFO occupancy, 0..DEPTH
- beat_count_o  out  16  accepted words, wraps at 16'hFFFF->0
- burst_done_o  out  1  one-cycle pulse when a CTI=111 beat is pushed
- seq_err_o  out  1  sticky, set on any err response; cleared by flush_i

## Operation
- req = cyc && stb. in_win = adr[31:WINDOW_LOG2] == BASE_ADDR[31:WINDOW_LOG2].
- FSM states: IDLE, ACK, ERR, RTY, GAP.
- IDLE/GAP, on req, evaluated in priority order: (!we || sel!=4'hF || !in_win || cti not in {000,010,111} || (cti==010 && bte!=00)) -> ERR; else occ_next==DEPTH -> RTY; else -> ACK, exp_adr <= adr.
- occ_next = level + push - pop for the current cycle.
- ACK: ack_o = !bad; err_o = bad, with bad = !in_win || (ADDR_CHECK && adr!=exp_adr). These are the only combinationally qualified outputs. When ack_o=1 and req: push dat_i, beat_count_o+1, exp_adr += 4.
- ACK next state: bad or !req -> GAP; cti==010 && occ_next<DEPTH -> stay ACK (back-to-back burst); else -> GAP.
- ERR, RTY: response held exactly one cycle -> GAP; seq_err_o set on ERR or bad.
- GAP: no response for one cycle, then evaluated as IDLE. A classic write therefore takes 2 cycles per word.
- Address compare uses the full 32 bits. A burst crossing the window end is errored at its first out-of-window beat; the beat is not pushed.
- Reads are always errored and never stall.
- flush_i: FIFO emptied, level_o=0, seq_err_o=0, state -> IDLE. Flush beats any push in the same cycle, so that beat is discarded even if acked. beat_count_o is not cleared.
- Simultaneous push and pop at level==DEPTH cannot occur. Push and pop at any other level leaves level_o unchanged.

## Timing
- Reset values: all acks/err/rty 0, valid_o 0, dat_o 0, level_o 0, beat_count_o 0, burst_done_o 0, seq_err_o 0, state IDLE.
- Reset mid-burst aborts immediately; FIFO contents are lost.
- Request in cycle N -> response in cycle N+1 (registered state).
- Burst throughput is 1 word/cycle while space remains.
- Push at edge E -> valid_o high after E (FWFT), so write-to-valid latency is 1 cycle.
- burst_done_o asserts in the cycle after the CTI=111 push.

## Configuration
- WB_BURST_SINK_ADDR_CHECK_EN defined: each beat after the first must equal exp_adr, otherwise err and the beat is discarded.
- Not defined: beat address is ignored beyond the in_win check, and data is pushed in arrival order.

## Test plan
- Classic write adr=BASE+0, dat=32'hDEADBEEF, cti=000 -> ack one cycle; valid_o=1 with dat_o=32'hDEADBEEF the next cycle; beat_count_o=1.
- Burst of 8 beats (cti 010 x7, then 111), ready_i=0 -> ack 8 consecutive cycles; level_o=8; single burst_done_o pulse.
- DEPTH_LOG2=2, 6-beat burst, ready_i=0 -> 4 acks then GAP, then rty. After ready_i pops 1, the retry at the same address is acked.
- Write to BASE+2^WINDOW_LOG2 -> err one cycle, no push, seq_err_o=1. Read inside window -> err.
- With ADDR_CHECK_EN, 3rd burst beat at exp+8 -> err, level_o=2. Without it -> ack, level_o=3.
- rst_i pulsed mid-burst with level_o=5 -> all outputs 0 asynchronously. A fresh classic write afterwards -> normal ack.
